// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Two writeback requesters share the single register-file write port.
//   req0 is ALU writeback and req1 is load writeback. Each requester has a
//   one-entry holding buffer with a valid/ready handshake. A round-robin
//   arbiter drains the buffers into the registered write-port outputs.
//   Writes to x0 are consumed without asserting RegWrite. chk_pending tells
//   the hazard logic that a write to chk_addr is buffered or in flight.
//
// Ports
//   clk, rst             clock (rising edge), async active-low reset
//   reqK_valid/ready     requester K handshake (K = 0, 1)
//   reqK_addr/data       requester K destination register and data
//   RegWrite             registered regfile write enable
//   writereg/writedata   registered regfile write address / data
//   chk_addr             register address being read by decode
//   chk_pending          a buffered or in-flight write targets chk_addr
//   idle                 both buffers empty and RegWrite low
module regfile_write_arbiter #(
    parameter int n  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [n-1:0]  req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [n-1:0]  req1_data,
    output logic          RegWrite,
    output logic [AW-1:0] writereg,
    output logic [n-1:0]  writedata,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_pending,
    output logic          idle
);

    // Holding buffers
    logic          buf0_v_q, buf0_v_d;
    logic [AW-1:0] buf0_addr_q, buf0_addr_d;
    logic [n-1:0]  buf0_data_q, buf0_data_d;
    logic          buf1_v_q, buf1_v_d;
    logic [AW-1:0] buf1_addr_q, buf1_addr_d;
    logic [n-1:0]  buf1_data_q, buf1_data_d;

    // Round-robin pointer: index of the buffer granted most recently
    logic          last_q, last_d;

    // Write-port output register
    logic          regwrite_q, regwrite_d;
    logic          wr_ok;
    logic [AW-1:0] writereg_q, writereg_d;
    logic [n-1:0]  writedata_q, writedata_d;

    logic          gnt0, gnt1, gnt_any;
    logic          acc0, acc1;
    logic [AW-1:0] gnt_addr;
    logic [n-1:0]  gnt_data;

    always_comb begin
        // Grant depends only on buffer state, so ready never depends on valid.
        gnt0    = buf0_v_q & (~buf1_v_q | last_q);
        gnt1    = buf1_v_q & (~buf0_v_q | ~last_q);
        gnt_any = gnt0 | gnt1;

        // A granted buffer drains this edge, so it can refill at the same edge.
        req0_ready = ~buf0_v_q | gnt0;
        req1_ready = ~buf1_v_q | gnt1;
        acc0       = req0_valid & req0_ready;
        acc1       = req1_valid & req1_ready;

        buf0_v_d    = acc0 | (buf0_v_q & ~gnt0);
        buf0_addr_d = acc0 ? req0_addr : buf0_addr_q;
        buf0_data_d = acc0 ? req0_data : buf0_data_q;
        buf1_v_d    = acc1 | (buf1_v_q & ~gnt1);
        buf1_addr_d = acc1 ? req1_addr : buf1_addr_q;
        buf1_data_d = acc1 ? req1_data : buf1_data_q;

        gnt_addr = gnt0 ? buf0_addr_q : buf1_addr_q;
        gnt_data = gnt0 ? buf0_data_q : buf1_data_q;
        last_d   = gnt_any ? gnt1 : last_q;

        // An x0 grant still consumes its turn but never reaches the regfile.
        wr_ok       = gnt_any & (gnt_addr != '0);
        regwrite_d  = wr_ok;
        writereg_d  = wr_ok ? gnt_addr : writereg_q;
        writedata_d = wr_ok ? gnt_data : writedata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf0_v_q    <= 1'b0;
            buf0_addr_q <= '0;
            buf0_data_q <= '0;
            buf1_v_q    <= 1'b0;
            buf1_addr_q <= '0;
            buf1_data_q <= '0;
            last_q      <= 1'b1;   // req0 wins the first contention
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            buf0_v_q    <= buf0_v_d;
            buf0_addr_q <= buf0_addr_d;
            buf0_data_q <= buf0_data_d;
            buf1_v_q    <= buf1_v_d;
            buf1_addr_q <= buf1_addr_d;
            buf1_data_q <= buf1_data_d;
            last_q      <= last_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign writereg  = writereg_q;
    assign writedata = writedata_q;

    // x0 is hardwired to zero, so it never carries a hazard.
    assign chk_pending = (chk_addr != '0) &
                         ((buf0_v_q & (buf0_addr_q == chk_addr)) |
                          (buf1_v_q & (buf1_addr_q == chk_addr)) |
                          (regwrite_q & (writereg_q == chk_addr)));

    assign idle = ~buf0_v_q & ~buf1_v_q & ~regwrite_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int n  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [n-1:0]  req0_data, req1_data;
    logic          RegWrite;
    logic [AW-1:0] writereg;
    logic [n-1:0]  writedata;
    logic [AW-1:0] chk_addr;
    logic          chk_pending;
    logic          idle;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.n(n), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .RegWrite   (RegWrite),
        .writereg   (writereg),
        .writedata  (writedata),
        .chk_addr   (chk_addr),
        .chk_pending(chk_pending),
        .idle       (idle)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [n-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [n-1:0] d1,
                         input logic [AW-1:0] ck);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        chk_addr   = ck;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Directed vector table: inputs for one cycle plus the outputs expected in that cycle
    typedef struct {
        logic v0; logic [AW-1:0] a0; logic [n-1:0] d0;
        logic v1; logic [AW-1:0] a1; logic [n-1:0] d1;
        logic [AW-1:0] ck;
        logic r0, r1, we; logic [AW-1:0] wr; logic [n-1:0] wd; logic pd, id;
    } vec_t;

    function automatic vec_t mk(logic v0, logic [AW-1:0] a0, logic [n-1:0] d0,
                                logic v1, logic [AW-1:0] a1, logic [n-1:0] d1,
                                logic [AW-1:0] ck, logic r0, logic r1, logic we,
                                logic [AW-1:0] wr, logic [n-1:0] wd, logic pd, logic id);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.ck = ck;
        v.r0 = r0; v.r1 = r1; v.we = we; v.wr = wr; v.wd = wd; v.pd = pd; v.id = id;
        return v;
    endfunction

    // Reference model: pending entries per requester and a preferred-winner flag
    typedef struct { logic [AW-1:0] addr; logic [n-1:0] data; } ent_t;
    ent_t          mq0[$];
    ent_t          mq1[$];
    int            m_pref;
    logic          m_we;
    logic [AW-1:0] m_reg;
    logic [n-1:0]  m_data;

    task automatic model_reset();
        mq0.delete(); mq1.delete();
        m_pref = 0; m_we = 0; m_reg = 0; m_data = 0;
    endtask

    // Compare current outputs against the model, then advance it across the next edge.
    task automatic model_cycle();
        int   g;
        logic er0, er1, epd, eid;
        ent_t e;
        g = -1;
        if (mq0.size() > 0 && mq1.size() > 0) g = m_pref;
        else if (mq0.size() > 0)               g = 0;
        else if (mq1.size() > 0)               g = 1;
        er0 = (mq0.size() == 0) || (g == 0);
        er1 = (mq1.size() == 0) || (g == 1);
        epd = 0;
        if (chk_addr != 0) begin
            foreach (mq0[i]) if (mq0[i].addr == chk_addr) epd = 1;
            foreach (mq1[i]) if (mq1[i].addr == chk_addr) epd = 1;
            if (m_we && m_reg == chk_addr) epd = 1;
        end
        eid = (mq0.size() == 0) && (mq1.size() == 0) && !m_we;
        check("rnd_ready0", req0_ready, er0);
        check("rnd_ready1", req1_ready, er1);
        check("rnd_regwrite", RegWrite, m_we);
        if (m_we) begin
            check("rnd_writereg", writereg, m_reg);
            check("rnd_writedata", writedata, m_data);
        end
        check("rnd_pending", chk_pending, epd);
        check("rnd_idle", idle, eid);
        m_we = 0;
        if (g == 0) begin e = mq0.pop_front(); m_pref = 1; end
        if (g == 1) begin e = mq1.pop_front(); m_pref = 0; end
        if (g >= 0 && e.addr != 0) begin
            m_we = 1; m_reg = e.addr; m_data = e.data;
        end
        if (req0_valid && er0) mq0.push_back('{req0_addr, req0_data});
        if (req1_valid && er1) mq1.push_back('{req1_addr, req1_data});
    endtask

    vec_t tbl[16];

    initial begin
        int i0, i1, run, max_run, first_wr;
        logic [AW-1:0] got_reg[$];
        logic [n-1:0]  got_dat[$];

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("reset_regwrite", RegWrite, 0);
        check("reset_writereg", writereg, 0);
        check("reset_writedata", writedata, 0);
        check("reset_idle", idle, 1);
        check("reset_ready0", req0_ready, 1);
        rst = 1'b1;

        //            v0 a0 d0      v1 a1 d1        ck  r0 r1 we wr wd       pd id
        tbl[0]  = mk(1, 5, 20,     1, 6, 100,      6,  1, 1, 0, 0, 0,       0, 1);
        tbl[1]  = mk(0, 0, 0,      0, 0, 0,        6,  1, 0, 0, 0, 0,       1, 0);
        tbl[2]  = mk(0, 0, 0,      0, 0, 0,        6,  1, 1, 1, 5, 20,      1, 0);
        tbl[3]  = mk(0, 0, 0,      0, 0, 0,        6,  1, 1, 1, 6, 100,     1, 0);
        tbl[4]  = mk(0, 0, 0,      0, 0, 0,        6,  1, 1, 0, 6, 100,     0, 1);
        tbl[5]  = mk(1, 5, 20,     0, 0, 0,        5,  1, 1, 0, 6, 100,     0, 1);
        tbl[6]  = mk(0, 0, 0,      0, 0, 0,        5,  1, 1, 0, 6, 100,     1, 0);
        tbl[7]  = mk(0, 0, 0,      0, 0, 0,        5,  1, 1, 1, 5, 20,      1, 0);
        tbl[8]  = mk(0, 0, 0,      0, 0, 0,        5,  1, 1, 0, 5, 20,      0, 1);
        tbl[9]  = mk(0, 0, 0,      1, 0, 'hFFFF,   0,  1, 1, 0, 5, 20,      0, 1);
        tbl[10] = mk(0, 0, 0,      0, 0, 0,        0,  1, 1, 0, 5, 20,      0, 0);
        tbl[11] = mk(0, 0, 0,      0, 0, 0,        0,  1, 1, 0, 5, 20,      0, 1);
        tbl[12] = mk(1, 7, 'h77,   0, 0, 0,        7,  1, 1, 0, 5, 20,      0, 1);
        tbl[13] = mk(0, 0, 0,      0, 0, 0,        7,  1, 1, 0, 5, 20,      1, 0);
        tbl[14] = mk(0, 0, 0,      0, 0, 0,        7,  1, 1, 1, 7, 'h77,    1, 0);
        tbl[15] = mk(0, 0, 0,      0, 0, 0,        7,  1, 1, 0, 7, 'h77,    0, 1);

        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            drive(tbl[k].v0, tbl[k].a0, tbl[k].d0, tbl[k].v1, tbl[k].a1, tbl[k].d1, tbl[k].ck);
            @(negedge clk);
            check($sformatf("vec%0d_ready0", k), req0_ready, tbl[k].r0);
            check($sformatf("vec%0d_ready1", k), req1_ready, tbl[k].r1);
            check($sformatf("vec%0d_regwrite", k), RegWrite, tbl[k].we);
            check($sformatf("vec%0d_writereg", k), writereg, tbl[k].wr);
            check($sformatf("vec%0d_writedata", k), writedata, tbl[k].wd);
            check($sformatf("vec%0d_pending", k), chk_pending, tbl[k].pd);
            check($sformatf("vec%0d_idle", k), idle, tbl[k].id);
        end

        // Sustained contention: three writes per requester, handshake-driven
        do_reset();
        i0 = 0; i1 = 0; run = 0; max_run = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            drive(i0 < 3, AW'(1 + 2*i0), n'((1 + 2*i0) * 11),
                  i1 < 3, AW'(2 + 2*i1), n'((2 + 2*i1) * 11), 0);
            @(negedge clk);
            if (RegWrite) begin
                got_reg.push_back(writereg);
                got_dat.push_back(writedata);
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (req0_valid && req0_ready) i0++;
            if (req1_valid && req1_ready) i1++;
        end
        check("contend_count", got_reg.size(), 6);
        check("contend_run", max_run, 6);
        for (int k = 0; k < got_reg.size() && k < 6; k++) begin
            check($sformatf("contend_reg%0d", k), got_reg[k], k + 1);
            check($sformatf("contend_data%0d", k), got_dat[k], (k + 1) * 11);
        end

        // Asynchronous reset mid-cycle while both buffers are full
        @(posedge clk); #1;
        drive(1, 9, 1, 1, 10, 2, 10);
        @(posedge clk); #1;
        drive(1, 11, 3, 0, 0, 0, 10);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 10);
        check("prereset_regwrite", RegWrite, 1);
        check("prereset_pending", chk_pending, 1);
        #2 rst = 1'b0;
        #1;
        check("midreset_regwrite", RegWrite, 0);
        check("midreset_idle", idle, 1);
        check("midreset_pending", chk_pending, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        drive(1, 12, 5, 1, 13, 6, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        first_wr = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (RegWrite && first_wr < 0) first_wr = writereg;
            @(posedge clk); #1;
        end
        check("postreset_first_winner", first_wr, 12);

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            drive($urandom_range(0, 2) != 0, AW'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 2) != 0, AW'($urandom_range(0, 3)), $urandom,
                  AW'($urandom_range(0, 3)));
            @(negedge clk);
            model_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
